// File: rtl/ecc_mem_ctrl_pkg.sv
// Shared types and constants for the ECC memory access sequencer.
package ecc_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WR      = 3'd2,
        ST_RD      = 3'd3,
        ST_RECOVER = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    localparam logic [1:0] CS_UP   = 2'b01;
    localparam logic [1:0] CS_DOWN = 2'b10;
    localparam logic [1:0] CS_IDLE = 2'b11;

    localparam int FLAG_CORR   = 0;
    localparam int FLAG_UNCORR = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; synchronous clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ecc_mem_access_seq.sv
// Sequences single MCU transactions onto the dual-bank ECC memory datapath
// with programmable strobe widths and saturating error statistics.
module ecc_mem_access_seq
    import ecc_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int WR_WAIT = 2,
    parameter int RD_WAIT = 3,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_bank,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_ecc_sel,
    output logic              rsp_valid,
    output logic [2:0]        rsp_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              dp_write_en_n,
    output logic              dp_output_en_n,
    output logic [1:0]        dp_chip_sel,
    output logic [2:0]        dp_ecc_sel,
    input  logic [2:0]        dp_flag,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_corr_cnt,
    output logic [CNT_W-1:0]  err_uncorr_cnt,
    output logic              busy
);

    localparam int WAIT_MAX = (WR_WAIT > RD_WAIT) ? WR_WAIT : RD_WAIT;
    localparam int WCNT_W   = $clog2(WAIT_MAX + 1);

    state_t              r_state;
    logic                r_we;
    logic [WCNT_W-1:0]   r_wait;
    logic [2:0]          r_flag_cap;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_write_en_n;
    logic                r_output_en_n;
    logic [1:0]          r_chip_sel;
    logic [2:0]          r_ecc_sel;
    logic                r_rsp_valid;
    logic [2:0]          r_rsp_flag;

    logic                w_rd_resp;
    logic                w_inc_corr;
    logic                w_inc_uncorr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_we          <= 1'b0;
            r_wait        <= '0;
            r_flag_cap    <= '0;
            r_mem_addr    <= '0;
            r_write_en_n  <= 1'b1;
            r_output_en_n <= 1'b1;
            r_chip_sel    <= CS_IDLE;
            r_ecc_sel     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_flag    <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_mem_addr <= req_addr;
                        r_chip_sel <= req_bank ? CS_DOWN : CS_UP;
                        r_ecc_sel  <= req_ecc_sel;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_we) begin
                        r_wait       <= WCNT_W'(WR_WAIT - 1);
                        r_write_en_n <= 1'b0;
                        r_state      <= ST_WR;
                    end else begin
                        r_wait        <= WCNT_W'(RD_WAIT - 1);
                        r_output_en_n <= 1'b0;
                        r_state       <= ST_RD;
                    end
                end
                ST_WR: begin
                    if (r_wait == '0) begin
                        r_write_en_n <= 1'b1;
                        r_state      <= ST_RECOVER;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_RD: begin
                    // Decoder flags are valid at the end of the last strobe cycle.
                    if (r_wait == '0) begin
                        r_flag_cap    <= dp_flag;
                        r_output_en_n <= 1'b1;
                        r_state       <= ST_RECOVER;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_flag  <= r_we ? 3'b000 : r_flag_cap;
                    r_chip_sel  <= CS_IDLE;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Uncorrectable dominates: a word flagged both ways counts only once.
    assign w_rd_resp    = (r_state == ST_RESP) && !r_we;
    assign w_inc_uncorr = w_rd_resp && r_rsp_flag[FLAG_UNCORR];
    assign w_inc_corr   = w_rd_resp && !r_rsp_flag[FLAG_UNCORR] && r_rsp_flag[FLAG_CORR];

    sat_counter #(.W(CNT_W)) u_corr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc_corr),
        .clr   (cnt_clr),
        .count (err_corr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_uncorr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc_uncorr),
        .clr   (cnt_clr),
        .count (err_uncorr_cnt)
    );

    assign req_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_flag       = r_rsp_flag;
    assign mem_addr       = r_mem_addr;
    assign dp_write_en_n  = r_write_en_n;
    assign dp_output_en_n = r_output_en_n;
    assign dp_chip_sel    = r_chip_sel;
    assign dp_ecc_sel     = r_ecc_sel;

endmodule

// File: tb/tb_ecc_mem_access_seq.sv
// Bench for ecc_mem_access_seq: vector table, scoreboard monitor, and hand-written corner sequences.
module tb_ecc_mem_access_seq;

    localparam int ADDR_W  = 16;
    localparam int WR_WAIT = 2;
    localparam int RD_WAIT = 3;
    localparam int CNT_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic              req_bank = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [2:0]        req_ecc_sel = '0;
    logic              rsp_valid;
    logic [2:0]        rsp_flag;
    logic [ADDR_W-1:0] mem_addr;
    logic              dp_write_en_n;
    logic              dp_output_en_n;
    logic [1:0]        dp_chip_sel;
    logic [2:0]        dp_ecc_sel;
    logic [2:0]        dp_flag = '0;
    logic              cnt_clr = 1'b0;
    logic [CNT_W-1:0]  err_corr_cnt;
    logic [CNT_W-1:0]  err_uncorr_cnt;
    logic              busy;

    ecc_mem_access_seq #(
        .ADDR_W (ADDR_W), .WR_WAIT(WR_WAIT), .RD_WAIT(RD_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bank(req_bank), .req_addr(req_addr), .req_ecc_sel(req_ecc_sel),
        .rsp_valid(rsp_valid), .rsp_flag(rsp_flag), .mem_addr(mem_addr),
        .dp_write_en_n(dp_write_en_n), .dp_output_en_n(dp_output_en_n),
        .dp_chip_sel(dp_chip_sel), .dp_ecc_sel(dp_ecc_sel), .dp_flag(dp_flag),
        .cnt_clr(cnt_clr), .err_corr_cnt(err_corr_cnt),
        .err_uncorr_cnt(err_uncorr_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic              we;
        logic [1:0]        cs;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        ecc;
        logic [2:0]        flag;
        int                acc;
    } sb_t;

    sb_t sb_q[$];
    sb_t h;
    int  acc_hist[$];
    int  wr_len = 0;
    int  rd_len = 0;

    // Monitor: scoreboard for every transaction, strobe widths, field stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            wr_len = 0;
            rd_len = 0;
        end else begin
            if (sb_q.size() > 0) begin
                h = sb_q[0];
                if (cyc == h.acc + 1) begin
                    check("setup_chip_sel", 32'(dp_chip_sel), 32'(h.cs));
                    check("setup_addr", 32'(mem_addr), 32'(h.addr));
                    check("setup_ecc_sel", 32'(dp_ecc_sel), 32'(h.ecc));
                    check("setup_strobes", 32'({dp_write_en_n, dp_output_en_n}), 32'h3);
                end
                if (!dp_write_en_n || !dp_output_en_n) begin
                    check("strobe_overlap", 32'(dp_write_en_n | dp_output_en_n), 32'h1);
                    check("hold_chip_sel", 32'(dp_chip_sel), 32'(h.cs));
                    check("hold_addr", 32'(mem_addr), 32'(h.addr));
                    check("hold_ecc_sel", 32'(dp_ecc_sel), 32'(h.ecc));
                end
            end
            if (!dp_write_en_n) wr_len++;
            else if (wr_len != 0) begin
                check("wr_strobe_len", 32'(wr_len), 32'(WR_WAIT));
                wr_len = 0;
            end
            if (!dp_output_en_n) rd_len++;
            else if (rd_len != 0) begin
                check("rd_strobe_len", 32'(rd_len), 32'(RD_WAIT));
                rd_len = 0;
            end
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (cycle %0d)", cyc);
                end else begin
                    h = sb_q.pop_front();
                    check("sb_rsp_flag", 32'(rsp_flag), 32'(h.flag));
                    check("sb_latency", 32'(cyc - h.acc), 32'((h.we ? WR_WAIT : RD_WAIT) + 3));
                    check("resp_chip_sel", 32'(dp_chip_sel), 32'h3);
                end
            end
            if (req_valid && req_ready) begin
                sb_q.push_back('{we: req_we, cs: (req_bank ? 2'b10 : 2'b01), addr: req_addr,
                                 ecc: req_ecc_sel, flag: (req_we ? 3'b000 : dp_flag), acc: cyc});
                acc_hist.push_back(cyc);
            end
        end
    end

    typedef struct {
        logic              we;
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        ecc;
        logic [2:0]        flag;
        logic              clr;
        logic [2:0]        exp_flag;
        logic [CNT_W-1:0]  exp_corr;
        logic [CNT_W-1:0]  exp_uncorr;
    } vec_t;

    vec_t vecs[8];

    task automatic do_txn(input vec_t v, input bit chk);
        int t;
        @(posedge clk); #1;
        req_we      = v.we;
        req_bank    = v.bank;
        req_addr    = v.addr;
        req_ecc_sel = v.ecc;
        dp_flag     = v.flag;
        req_valid   = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got req_ready=0, expected 1 within 20 cycles");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom);
        req_bank  = ~v.bank;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_timeout: got rsp_valid=0, expected 1 within 20 cycles");
        end else begin
            check("vec_rsp_flag", 32'(rsp_flag), 32'(v.exp_flag));
            if (v.clr) cnt_clr = 1'b1;
        end
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        if (chk) begin
            check("corr_cnt", 32'(err_corr_cnt), 32'(v.exp_corr));
            check("uncorr_cnt", 32'(err_uncorr_cnt), 32'(v.exp_uncorr));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int n_acc;
        vec_t v;

        //          we    bank  addr      ecc     flag    clr   exp_flag corr   uncorr
        vecs[0] = '{1'b1, 1'b0, 16'h0040, 3'b000, 3'b000, 1'b0, 3'b000, 8'd0, 8'd0};
        vecs[1] = '{1'b0, 1'b1, 16'h1234, 3'b010, 3'b001, 1'b0, 3'b001, 8'd1, 8'd0};
        vecs[2] = '{1'b0, 1'b0, 16'h00FF, 3'b101, 3'b011, 1'b0, 3'b011, 8'd1, 8'd1};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 3'b111, 3'b010, 1'b0, 3'b010, 8'd1, 8'd2};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 3'b001, 3'b000, 1'b0, 3'b000, 8'd1, 8'd2};
        vecs[5] = '{1'b1, 1'b1, 16'hABCD, 3'b110, 3'b011, 1'b0, 3'b000, 8'd1, 8'd2};
        vecs[6] = '{1'b0, 1'b1, 16'h5A5A, 3'b011, 3'b101, 1'b0, 3'b101, 8'd2, 8'd2};
        vecs[7] = '{1'b0, 1'b0, 16'h8001, 3'b100, 3'b100, 1'b0, 3'b100, 8'd2, 8'd2};

        repeat (2) @(negedge clk);
        check("rst_write_en_n", 32'(dp_write_en_n), 32'h1);
        check("rst_output_en_n", 32'(dp_output_en_n), 32'h1);
        check("rst_chip_sel", 32'(dp_chip_sel), 32'h3);
        check("rst_ecc_sel", 32'(dp_ecc_sel), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_flag", 32'(rsp_flag), 32'h0);
        check("rst_corr_cnt", 32'(err_corr_cnt), 32'h0);
        check("rst_uncorr_cnt", 32'(err_uncorr_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) do_txn(vecs[i], 1'b1);

        // Uncorrectable counter saturates; corrected count untouched.
        v = '{1'b0, 1'b1, 16'h0101, 3'b010, 3'b011, 1'b0, 3'b011, 8'd0, 8'd0};
        for (int i = 0; i < 255; i++) do_txn(v, 1'b0);
        check("sat_uncorr", 32'(err_uncorr_cnt), 32'hFF);
        check("sat_uncorr_corr_kept", 32'(err_corr_cnt), 32'h2);

        v = '{1'b0, 1'b0, 16'h0202, 3'b001, 3'b001, 1'b0, 3'b001, 8'd0, 8'd0};
        for (int i = 0; i < 256; i++) do_txn(v, 1'b0);
        check("sat_corr", 32'(err_corr_cnt), 32'hFF);
        check("sat_corr_uncorr_kept", 32'(err_uncorr_cnt), 32'hFF);

        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_corr", 32'(err_corr_cnt), 32'h0);
        check("clr_uncorr", 32'(err_uncorr_cnt), 32'h0);

        // Clear coinciding with an increment leaves zero.
        do_txn('{1'b0, 1'b1, 16'h0303, 3'b010, 3'b001, 1'b1, 3'b001, 8'd0, 8'd0}, 1'b1);
        do_txn('{1'b0, 1'b1, 16'h0304, 3'b010, 3'b001, 1'b0, 3'b001, 8'd1, 8'd0}, 1'b1);

        // Asynchronous reset during the second read-strobe cycle.
        @(posedge clk); #1;
        req_we = 1'b0; req_bank = 1'b1; req_addr = 16'h0777; req_ecc_sel = 3'b010;
        dp_flag = 3'b011; req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("abort_in_rd", 32'(dp_output_en_n), 32'h0);
        rst_n = 1'b0;
        #1;
        check("abort_write_en_n", 32'(dp_write_en_n), 32'h1);
        check("abort_output_en_n", 32'(dp_output_en_n), 32'h1);
        check("abort_chip_sel", 32'(dp_chip_sel), 32'h3);
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready), 32'h1);
        check("abort_corr_cnt", 32'(err_corr_cnt), 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // Request held valid: back-to-back writes, inputs churn while busy.
        start = acc_hist.size();
        @(posedge clk); #1;
        req_we = 1'b1; req_bank = 1'b0; req_addr = 16'h1111; req_ecc_sel = 3'b001;
        dp_flag = 3'b000; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            req_addr    = ADDR_W'($urandom);
            req_bank    = 1'($urandom);
            req_ecc_sel = 3'($urandom);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("b2b_idle", 32'(busy), 32'h0);
        n_acc = acc_hist.size() - start;
        check("b2b_accepts", 32'(n_acc >= 3), 32'h1);
        for (int i = start + 1; i < acc_hist.size(); i++)
            check("b2b_spacing", 32'(acc_hist[i] - acc_hist[i-1]), 32'(WR_WAIT + 4));
        check("b2b_sb_drained", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
